// File: rtl/padder_pkg.sv
// Shared types and helpers for the stream padder: FSM states, pad byte and
// the valid-byte mask used to zero the unused tail of a last word.
package padder_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_OUT   = 2'd1,
    S_EXTRA = 2'd2
  } state_t;

  localparam int         LEN_W    = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int         MASK_W   = 256;

  // Byte-enable style mask: the lowest nbytes bytes are all ones.
  function automatic logic [MASK_W-1:0] byte_mask(input logic [7:0] nbytes);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int k = 0; k < MASK_W/8; k++) begin
      if (k < int'(nbytes)) begin
        m[8*k +: 8] = 8'hff;
      end else begin
        m[8*k +: 8] = 8'h00;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_padder_pad_insert.sv
// Places one input word at its slot within a block-wide vector; for a last
// word it zeroes the invalid bytes and drops the pad byte right after them.
module pad_insert
  import padder_pkg::*;
#(
  parameter int IWIDTH = 128,
  parameter int BWIDTH = 32
) (
  input  logic [BWIDTH-1:0]                  word,
  input  logic [$clog2(BWIDTH/8+1)-1:0]      nbytes,
  input  logic [$clog2(IWIDTH/BWIDTH)-1:0]   slot,
  input  logic                               last,
  output logic [IWIDTH-1:0]                  merged,
  output logic                               pad_placed
);

  localparam int BPB = BWIDTH/8;
  localparam int NB  = IWIDTH/8;

  logic [MASK_W-1:0] full_mask_s;
  logic              unused_mask_s;
  int                pos_s;

  assign full_mask_s   = byte_mask(8'(nbytes));
  assign unused_mask_s = ^full_mask_s[MASK_W-1:BWIDTH];

  // Merge the word into its slot; the pad byte may land in the next slot.
  always_comb begin
    merged     = '0;
    pad_placed = 1'b0;
    pos_s      = int'(slot)*BPB + int'(nbytes);
    if (last) begin
      merged[int'(slot)*BWIDTH +: BWIDTH] = word & full_mask_s[BWIDTH-1:0];
      if (pos_s < NB) begin
        merged[pos_s*8 +: 8] = merged[pos_s*8 +: 8] | PAD_BYTE;
        pad_placed           = 1'b1;
      end else begin
        pad_placed = 1'b0;
      end
    end else begin
      merged[int'(slot)*BWIDTH +: BWIDTH] = word;
    end
  end

endmodule

// File: rtl/stream_padder.sv
// Word-stream to block assembler with final-block padding and overflow block.
// Define PADDER_LEN_TRAILER_EN to append a 64-bit bit-length trailer instead of the MSB marker.
module stream_padder
  import padder_pkg::*;
#(
  parameter int IWIDTH = 128,
  parameter int BWIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BWIDTH-1:0]             in_data,
  input  logic                          in_last,
  input  logic [$clog2(BWIDTH/8+1)-1:0] in_bytes,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IWIDTH-1:0]             out_block,
  output logic                          out_last,
  output logic                          padded
);

  localparam int WPB = IWIDTH/BWIDTH;
  localparam int BPB = BWIDTH/8;
  localparam int SW  = $clog2(WPB);

  state_t             state_r, state_s;
  logic [SW-1:0]      wcnt_r, wcnt_s;
  logic [LEN_W-1:0]   len_r, len_s, len_inc_s;
  logic               pend_r, pend_s, owed_r, owed_s;
  logic [IWIDTH-1:0]  block_r, block_s, blk_v;
  logic               last_r, last_s, padded_r, padded_s, fits_s;
  logic               out_valid_r, in_ready_r;
  logic [IWIDTH-1:0]  merged_s;
  logic               pad_placed_s;

`ifdef PADDER_LEN_TRAILER_EN
  localparam int NB = IWIDTH/8;

  function automatic logic [IWIDTH-1:0] with_trailer(input logic [IWIDTH-1:0] blk,
                                                     input logic [LEN_W-1:0]  len);
    logic [IWIDTH-1:0] r;
    r = blk;
    r[IWIDTH-1 -: LEN_W] = {len[LEN_W-4:0], 3'b000};
    return r;
  endfunction
`else
  function automatic logic [IWIDTH-1:0] with_trailer(input logic [IWIDTH-1:0] blk);
    logic [IWIDTH-1:0] r;
    r = blk;
    r[IWIDTH-1] = 1'b1;
    return r;
  endfunction
`endif

  pad_insert #(.IWIDTH(IWIDTH), .BWIDTH(BWIDTH)) u_pad_insert (
    .word       (in_data),
    .nbytes     (in_bytes),
    .slot       (wcnt_r),
    .last       (in_last),
    .merged     (merged_s),
    .pad_placed (pad_placed_s)
  );

  // Next-state, block assembly and length accounting.
  always_comb begin
    state_s   = state_r;
    wcnt_s    = wcnt_r;
    len_s     = len_r;
    pend_s    = pend_r;
    owed_s    = owed_r;
    block_s   = block_r;
    last_s    = last_r;
    padded_s  = padded_r;
    fits_s    = 1'b0;
    blk_v     = '0;
    len_inc_s = in_last ? 64'(in_bytes) : 64'(BPB);
    case (state_r)
      S_FILL: begin
        if (in_valid && in_ready_r) begin
          block_s = block_r | merged_s;
          len_s   = len_r + len_inc_s;
          if (!in_last) begin
            if (wcnt_r == SW'(WPB-1)) begin
              state_s  = S_OUT;
              last_s   = 1'b0;
              padded_s = 1'b0;
            end else begin
              wcnt_s = wcnt_r + SW'(1);
            end
          end else begin
`ifdef PADDER_LEN_TRAILER_EN
            fits_s = (int'(wcnt_r)*BPB + int'(in_bytes)) <= (NB-9);
`else
            fits_s = pad_placed_s;
`endif
            state_s = S_OUT;
            if (fits_s) begin
`ifdef PADDER_LEN_TRAILER_EN
              block_s = with_trailer(block_s, len_s);
`else
              block_s = with_trailer(block_s);
`endif
              last_s   = 1'b1;
              padded_s = 1'b1;
            end else begin
              // Trailer spills into an extra block; remember whether the pad byte did too.
              last_s   = 1'b0;
              pend_s   = 1'b1;
              padded_s = pad_placed_s;
              owed_s   = !pad_placed_s;
            end
          end
        end else begin
          state_s = S_FILL;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (pend_r) begin
            state_s = S_EXTRA;
          end else begin
            state_s  = S_FILL;
            wcnt_s   = '0;
            pend_s   = 1'b0;
            owed_s   = 1'b0;
            block_s  = '0;
            last_s   = 1'b0;
            padded_s = 1'b0;
            if (last_r) begin
              len_s = '0;
            end else begin
              len_s = len_r;
            end
          end
        end else begin
          state_s = S_OUT;
        end
      end
      S_EXTRA: begin
        if (owed_r) begin
          blk_v[7:0] = PAD_BYTE;
        end else begin
          blk_v[7:0] = 8'h00;
        end
`ifdef PADDER_LEN_TRAILER_EN
        block_s = with_trailer(blk_v, len_r);
`else
        block_s = with_trailer(blk_v);
`endif
        last_s   = 1'b1;
        padded_s = 1'b1;
        pend_s   = 1'b0;
        owed_s   = 1'b0;
        state_s  = S_OUT;
      end
      default: begin
        state_s = S_FILL;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_FILL;
      wcnt_r      <= '0;
      len_r       <= '0;
      pend_r      <= 1'b0;
      owed_r      <= 1'b0;
      block_r     <= '0;
      last_r      <= 1'b0;
      padded_r    <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      wcnt_r      <= wcnt_s;
      len_r       <= len_s;
      pend_r      <= pend_s;
      owed_r      <= owed_s;
      block_r     <= block_s;
      last_r      <= last_s;
      padded_r    <= padded_s;
      out_valid_r <= (state_s == S_OUT);
      in_ready_r  <= (state_s == S_FILL);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_block = block_r;
  assign out_last  = last_r;
  assign padded    = padded_r;

endmodule

// File: tb/tb_stream_padder.sv
// Directed self-checking bench for stream_padder (IWIDTH=128, BWIDTH=32);
// expected blocks are hand-computed constants.
module tb_stream_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         out_valid, out_ready, out_last, padded;
  logic [127:0] out_block;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  stream_padder #(.IWIDTH(128), .BWIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_last  (out_last),
    .padded    (padded)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] nb);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_bytes = nb;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("send_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
    in_data  = 32'h0;
  endtask

  task automatic take(input string tag, input logic [127:0] eb, input logic el, input logic ep);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 128'(out_valid), 128'd1);
    chk({tag, "_block"}, out_block, eb);
    chk({tag, "_last"}, 128'(out_last), 128'(el));
    chk({tag, "_padded"}, 128'(padded), 128'(ep));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h12345678;
    in_last   = 1'b1;
    in_bytes  = 3'd2;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    chk("rst_out_last", 128'(out_last), 128'd0);
    chk("rst_padded", 128'(padded), 128'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
    tick();
    chk("idle_out_valid", 128'(out_valid), 128'd0);

`ifdef PADDER_LEN_TRAILER_EN
    send(32'h11223344, 1'b0, 3'd0);
    send(32'h00ccbbaa, 1'b1, 3'd3);
    chk("m7_latency", 128'(out_valid), 128'd1);
    take("m7", 128'h00000000_00000038_80ccbbaa_11223344, 1'b1, 1'b1);

    send(32'h11223344, 1'b0, 3'd0);
    send(32'h55667788, 1'b1, 3'd4);
    take("m8a", 128'h00000000_00000080_55667788_11223344, 1'b0, 1'b1);
    chk("m8_gap", 128'(out_valid), 128'd0);
    tick();
    chk("m8_reassert", 128'(out_valid), 128'd1);
    take("m8b", 128'h00000000_00000040_00000000_00000000, 1'b1, 1'b1);

    send(32'h11111111, 1'b0, 3'd0);
    send(32'h22222222, 1'b0, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out_valid", 128'(out_valid), 128'd0);
    send(32'h0000005a, 1'b1, 3'd1);
    take("mrst", 128'h00000000_00000008_00000000_0000805a, 1'b1, 1'b1);
`else
    send(32'h44332211, 1'b1, 3'd3);
    chk("t1_latency", 128'(out_valid), 128'd1);
    take("t1", 128'h80000000_00000000_00000000_80332211, 1'b1, 1'b1);
    chk("t1_ready", 128'(in_ready), 128'd1);

    send(32'h03020100, 1'b0, 3'd0);
    send(32'h07060504, 1'b0, 3'd0);
    send(32'h0b0a0908, 1'b0, 3'd0);
    send(32'h0f0e0d0c, 1'b1, 3'd4);
    chk("t2_latency", 128'(out_valid), 128'd1);
    take("t2a", 128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0, 1'b0);
    chk("t2_gap", 128'(out_valid), 128'd0);
    chk("t2_gap_ready", 128'(in_ready), 128'd0);
    tick();
    chk("t2_reassert", 128'(out_valid), 128'd1);
    take("t2b", 128'h80000000_00000000_00000000_00000080, 1'b1, 1'b1);

    send(32'hdeadbeef, 1'b1, 3'd0);
    take("t3", 128'h80000000_00000000_00000000_00000080, 1'b1, 1'b1);

    send(32'h01020304, 1'b0, 3'd0);
    send(32'haabbccdd, 1'b1, 3'd2);
    in_valid = 1'b1;
    in_data  = 32'h000000ee;
    in_last  = 1'b1;
    in_bytes = 3'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_block", out_block, 128'h80000000_00000000_0080ccdd_01020304);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
    chk("bp_next_latency", 128'(out_valid), 128'd1);
    take("bp_next", 128'h80000000_00000000_00000000_000080ee, 1'b1, 1'b1);

    send(32'h11111111, 1'b0, 3'd0);
    send(32'h22222222, 1'b0, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_out_valid", 128'(out_valid), 128'd0);
    chk("rst2_in_ready", 128'(in_ready), 128'd1);
    send(32'h0000005a, 1'b1, 3'd1);
    take("rst2", 128'h80000000_00000000_00000000_0000805a, 1'b1, 1'b1);
`endif

    chk("end_in_ready", 128'(in_ready), 128'd1);
    chk("end_out_valid", 128'(out_valid), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
